ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide execution unit with HI/LO registers for the 5-stage MIPS pipeline.
//  Sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
//  Iterative radix-2 datapath; busy output feeds the hazard unit, which stalls PC, IF/ID and MFHI/MFLO.
//  Flush-aware: an in-flight op can be aborted when its instruction is squashed.
// PARAMETERS
//  DATA_W    32  operand/HI/LO width (>=4, even)
//  MUL_FAST  0   1 = single-cycle multiply (uses *), 0 = iterative shift-add
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low
//  start      in   1       launch op this cycle (sampled when state IDLE)
//  op         in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val     in   DATA_W  multiplicand / dividend (post-forwarding)
//  rt_val     in   DATA_W  multiplier / divisor (post-forwarding)
//  abort      in   1       kill in-flight op (pipeline flush)
//  hi_wr      in   1       MTHI: HI <= wr_data
//  lo_wr      in   1       MTLO: LO <= wr_data
//  wr_data    in   DATA_W  MTHI/MTLO data
//  busy       out  1       op in progress (state != IDLE)
//  done       out  1       1-cycle pulse: HI/LO just updated by an op
//  div_zero   out  1       last DIV/DIVU had rt_val==0; cleared on next accepted start
//  hi         out  DATA_W  HI register
//  lo         out  DATA_W  LO register
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, counter 0, hi=lo=0, busy=done=div_zero=0.
//  States: IDLE, CALC, FIX.
//  IDLE --start & ~abort--> CALC at edge E0.
//   - Signed ops latch operand magnitudes and sign flags; unsigned ops latch raw operands.
//   - Counter is cleared.
//  MUL_FAST=1 and op is MULT/MULTU: IDLE -> FIX directly at E0 with the full 2*DATA_W product latched.
//  DIV/DIVU with rt_val==0: IDLE -> FIX directly at E0, flagged divide-by-zero.
//  CALC: one iteration per edge for DATA_W edges (E1..E_DATA_W), then -> FIX.
//   - MUL: shift-add over 2*DATA_W accumulator, unsigned magnitudes.
//   - DIV: restoring divide giving quotient and remainder of the magnitudes.
//  FIX: one edge (E_DATA_W+1, or E1 for the fast/zero paths).
//   - Apply signs, write HI/LO, done=1 for the following cycle, -> IDLE.
//  Latency: iterative = DATA_W+2 edges start->done; fast/zero path = 2 edges.
//   - busy is high from the cycle after E0 through the FIX cycle.
//  Result rules:
//   - MUL: {HI,LO} = 2*DATA_W product; signed product negated iff operand signs differ.
//   - DIV: LO = quotient, truncated toward zero; HI = remainder, same sign as dividend.
//   - Most-negative / -1 (DIV): LO = most-negative, HI = 0 (natural wrap, no flag).
//   - Divide by zero: LO = all ones, HI = rs_val, div_zero=1.
//  hi/lo hold their old values throughout busy.
//  Only FIX or MTHI/MTLO change hi/lo.
//  hi_wr/lo_wr: honoured only in IDLE; ignored while busy.
//   - If hi_wr and start occur in the same IDLE cycle, the MTHI write lands and the op's FIX later overwrites it.
//  start while busy: ignored, no queuing.
//  abort: at next edge, any state -> IDLE; hi/lo and div_zero unchanged; no done.
//   - abort with start in the same cycle: abort wins, op not accepted.
//  Reset asserted mid-op: immediate return to reset values.
//   - First op after reset release behaves normally.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 34 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy high 33 cycles.
//  MULT -3*5 (0xFFFFFFFD, 5) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; repeat with MUL_FAST=1 -> done 2 edges after start.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  DIVU 7/0 -> done 2 edges after start; LO=0xFFFFFFFF, HI=7, div_zero=1; next accepted start clears div_zero.
//  DIV 100/7 -> abort at 10th CALC cycle -> busy low next cycle, no done, HI/LO keep prior values.
//   - start and hi_wr pulsed while busy are ignored; reset low mid-CALC -> all outputs 0.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Bundle of the EX-stage multiply/divide request, MTHI/MTLO and result signals.
// The pipeline side drives through the master modport; the execution unit uses slave.
interface ex_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              abort;
  logic              hi_wr;
  logic              lo_wr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, abort, hi_wr, lo_wr, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, abort, hi_wr, lo_wr, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Radix-2 shift-add multiply and restoring divide run on operand magnitudes;
// signs are applied in a final FIX cycle that also writes HI/LO.
// An optional single-cycle multiplier bypasses the iteration for MULT/MULTU.
module ex_muldiv_unit #(
  parameter int DATA_W   = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input logic             clk,
  input logic             reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int ACC_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [ACC_W-1:0]  acc_r;
  logic [DATA_W-1:0] b_r;       // multiplicand / divisor magnitude
  logic              is_mul_r;
  logic              neg_q_r;   // negate product (MUL) or quotient (DIV)
  logic              neg_r_r;   // negate remainder (DIV)
  logic              dz_pend_r; // op in flight is a divide by zero
  logic              busy_r;
  logic              done_r;
  logic              div_zero_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  logic              signed_op_s;
  logic              is_mul_op_s;
  logic [DATA_W-1:0] a_mag_s;
  logic [DATA_W-1:0] b_mag_s;
  logic [DATA_W:0]   mul_sum_s;
  logic [ACC_W-1:0]  mul_step_s;
  logic [DATA_W:0]   div_shift_s;
  logic [DATA_W:0]   div_diff_s;
  logic [ACC_W-1:0]  div_step_s;
  logic [ACC_W-1:0]  fast_prod_s;
  logic [ACC_W-1:0]  prod_fix_s;
  logic [DATA_W-1:0] res_hi_s;
  logic [DATA_W-1:0] res_lo_s;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] v,
                                              input logic              signed_op);
    logic [DATA_W-1:0] m;
    if (signed_op && v[DATA_W-1]) begin
      m = -v;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Decode the incoming op and take operand magnitudes.
  always_comb begin
    signed_op_s = ~bus.op[0];
    is_mul_op_s = ~bus.op[1];
    a_mag_s     = mag_f(bus.rs_val, signed_op_s);
    b_mag_s     = mag_f(bus.rt_val, signed_op_s);
  end

  // One radix-2 iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[ACC_W-1:DATA_W]}
                + (acc_r[0] ? {1'b0, b_r} : {(DATA_W + 1){1'b0}});
    mul_step_s  = {mul_sum_s, acc_r[DATA_W-1:1]};
    div_shift_s = {acc_r[ACC_W-1:DATA_W], acc_r[DATA_W-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (div_shift_s >= {1'b0, b_r}) begin
      div_step_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
    end else begin
      div_step_s = {div_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
    end
  end

  generate
    if (MUL_FAST) begin : g_fast_mul
      assign fast_prod_s = ACC_W'(a_mag_s) * ACC_W'(b_mag_s);
    end else begin : g_no_fast_mul
      assign fast_prod_s = {ACC_W{1'b0}};
    end
  endgenerate

  // Apply result signs; a divide-by-zero carries its final HI/LO in acc_r unsigned.
  always_comb begin
    prod_fix_s = neg_q_r ? -acc_r : acc_r;
    if (is_mul_r) begin
      res_hi_s = prod_fix_s[ACC_W-1:DATA_W];
      res_lo_s = prod_fix_s[DATA_W-1:0];
    end else begin
      res_lo_s = neg_q_r ? -acc_r[DATA_W-1:0] : acc_r[DATA_W-1:0];
      res_hi_s = neg_r_r ? -acc_r[ACC_W-1:DATA_W] : acc_r[ACC_W-1:DATA_W];
    end
  end

  // Control FSM, datapath registers and HI/LO with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      b_r        <= {DATA_W{1'b0}};
      is_mul_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_pend_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {DATA_W{1'b0}};
      lo_r       <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.hi_wr) begin
            hi_r <= bus.wr_data;
          end
          if (bus.lo_wr) begin
            lo_r <= bus.wr_data;
          end
          if (bus.start && !bus.abort) begin
            cnt_r      <= {CNT_W{1'b0}};
            div_zero_r <= 1'b0;
            is_mul_r   <= is_mul_op_s;
            b_r        <= b_mag_s;
            busy_r     <= 1'b1;
            if (is_mul_op_s) begin
              neg_q_r   <= signed_op_s & (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
              neg_r_r   <= 1'b0;
              dz_pend_r <= 1'b0;
              if (MUL_FAST) begin
                acc_r   <= fast_prod_s;
                state_r <= ST_FIX;
              end else begin
                acc_r   <= {{DATA_W{1'b0}}, a_mag_s};
                state_r <= ST_CALC;
              end
            end else if (bus.rt_val == {DATA_W{1'b0}}) begin
              // Divide by zero: result is fixed, skip the iteration.
              acc_r     <= {bus.rs_val, {DATA_W{1'b1}}};
              neg_q_r   <= 1'b0;
              neg_r_r   <= 1'b0;
              dz_pend_r <= 1'b1;
              state_r   <= ST_FIX;
            end else begin
              acc_r     <= {{DATA_W{1'b0}}, a_mag_s};
              neg_q_r   <= signed_op_s & (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
              neg_r_r   <= signed_op_s & bus.rs_val[DATA_W-1];
              dz_pend_r <= 1'b0;
              state_r   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bus.abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r <= is_mul_r ? mul_step_s : div_step_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          if (!bus.abort) begin
            hi_r       <= res_hi_s;
            lo_r       <= res_lo_s;
            done_r     <= 1'b1;
            div_zero_r <= dz_pend_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an iterative instance (index 0) and a
// fast-multiply instance (index 1) are checked against an arithmetic model.
module tb_ex_muldiv_unit;

  logic clk;
  logic reset;

  logic [1:0]       start_v;
  logic [1:0][1:0]  op_v;
  logic [1:0][31:0] rs_v;
  logic [1:0][31:0] rt_v;
  logic [1:0]       abort_v;
  logic [1:0]       hi_wr_v;
  logic [1:0]       lo_wr_v;
  logic [1:0][31:0] wr_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;
  logic [1:0]       dz_v;
  logic [1:0][31:0] hi_v;
  logic [1:0][31:0] lo_v;

  int total;
  int bad;

  ex_muldiv_unit_if #(.DATA_W(32)) bs ();
  ex_muldiv_unit_if #(.DATA_W(32)) bf ();

  ex_muldiv_unit #(.DATA_W(32), .MUL_FAST(1'b0)) dut_s (.clk(clk), .reset(reset), .bus(bs));
  ex_muldiv_unit #(.DATA_W(32), .MUL_FAST(1'b1)) dut_f (.clk(clk), .reset(reset), .bus(bf));

  assign bs.start = start_v[0];  assign bf.start = start_v[1];
  assign bs.op = op_v[0];        assign bf.op = op_v[1];
  assign bs.rs_val = rs_v[0];    assign bf.rs_val = rs_v[1];
  assign bs.rt_val = rt_v[0];    assign bf.rt_val = rt_v[1];
  assign bs.abort = abort_v[0];  assign bf.abort = abort_v[1];
  assign bs.hi_wr = hi_wr_v[0];  assign bf.hi_wr = hi_wr_v[1];
  assign bs.lo_wr = lo_wr_v[0];  assign bf.lo_wr = lo_wr_v[1];
  assign bs.wr_data = wr_v[0];   assign bf.wr_data = wr_v[1];
  assign busy_v = {bf.busy, bs.busy};
  assign done_v = {bf.done, bs.done};
  assign dz_v   = {bf.div_zero, bs.div_zero};
  assign hi_v[0] = bs.hi;        assign hi_v[1] = bf.hi;
  assign lo_v[0] = bs.lo;        assign lo_v[1] = bf.lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {div_zero, HI, LO} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {a % b, a / b};
      end
    endcase
    return {1'b0, p};
  endfunction

  // Launch one op on instance d and check latency, busy length, HI/LO hold and result.
  task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit mthi, input logic [31:0] wd,
                        input string tag);
    logic [64:0] e;
    logic [31:0] pre_hi, pre_lo;
    int n, nb, lat;
    bit hold_bad, dz_first;
    e = model(o, a, b);
    lat = ((o[1] && b == 32'h0) || (d == 1 && !o[1])) ? 2 : 34;
    @(negedge clk);
    pre_hi = mthi ? wd : hi_v[d];
    pre_lo = lo_v[d];
    start_v[d] = 1'b1; op_v[d] = o; rs_v[d] = a; rt_v[d] = b;
    hi_wr_v[d] = mthi; wr_v[d] = wd;
    n = 0; nb = 0; hold_bad = 1'b0; dz_first = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start_v[d] = 1'b0; hi_wr_v[d] = 1'b0;
      if (n == 1) dz_first = dz_v[d];
      if (done_v[d]) break;
      if (busy_v[d]) begin
        nb++;
        if (hi_v[d] !== pre_hi || lo_v[d] !== pre_lo) hold_bad = 1'b1;
      end
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(lat - 1));
    check({tag, "_hold"}, 64'(hold_bad), 64'(0));
    check({tag, "_dz_cleared"}, 64'(dz_first), 64'(0));
    check({tag, "_hi"}, 64'(hi_v[d]), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo_v[d]), 64'(e[31:0]));
    check({tag, "_dz"}, 64'(dz_v[d]), 64'(e[64]));
  endtask

  initial begin
    logic [31:0] pre_hi, pre_lo;
    bit seen_done;
    total = 0; bad = 0;
    reset = 1'b0;
    start_v = 2'b00; op_v = '0; rs_v = '0; rt_v = '0; abort_v = 2'b00;
    hi_wr_v = 2'b00; lo_wr_v = 2'b00; wr_v = '0;

    // Reset state
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", 64'(busy_v[d]), 64'(0));
      check("rst_done", 64'(done_v[d]), 64'(0));
      check("rst_dz", 64'(dz_v[d]), 64'(0));
      check("rst_hi", 64'(hi_v[d]), 64'(0));
      check("rst_lo", 64'(lo_v[d]), 64'(0));
    end
    @(negedge clk); reset = 1'b1;

    // Directed cases
    run_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, "multu_max");
    check("multu_max_hi_const", 64'(hi_v[0]), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(lo_v[0]), 64'h0000_0000_0000_0001);
    run_op(0, 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0, "mult_m3x5");
    run_op(1, 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0, "mult_m3x5_fast");
    check("mult_fast_lo_const", 64'(lo_v[1]), 64'h0000_0000_FFFF_FFF1);
    run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0, "div_m7_2");
    check("div_m7_2_lo_const", 64'(lo_v[0]), 64'h0000_0000_FFFF_FFFD);
    run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, "div_minneg");
    run_op(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, "div_minneg_f");
    run_op(0, 2'b11, 32'd7, 32'd0, 1'b0, 32'h0, "divu_zero");
    run_op(0, 2'b11, 32'd50, 32'd3, 1'b1, 32'h1234_5678, "divu_mthi_same");
    run_op(0, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0, "mult_extremes");

    // MTHI/MTLO in IDLE
    @(negedge clk); hi_wr_v[0] = 1'b1; lo_wr_v[0] = 1'b1; wr_v[0] = 32'hA5A5_0F0F;
    @(negedge clk); hi_wr_v[0] = 1'b0; lo_wr_v[0] = 1'b0;
    check("mt_hi", 64'(hi_v[0]), 64'h0000_0000_A5A5_0F0F);
    check("mt_lo", 64'(lo_v[0]), 64'h0000_0000_A5A5_0F0F);

    // Abort together with start: op must not be accepted
    start_v[0] = 1'b1; abort_v[0] = 1'b1; op_v[0] = 2'b10; rs_v[0] = 32'd9; rt_v[0] = 32'd2;
    @(negedge clk); start_v[0] = 1'b0; abort_v[0] = 1'b0;
    check("abort_start_busy", 64'(busy_v[0]), 64'(0));

    // DIV 100/7 aborted in its 10th CALC cycle; start/MTHI while busy ignored
    pre_hi = hi_v[0]; pre_lo = lo_v[0];
    start_v[0] = 1'b1; op_v[0] = 2'b10; rs_v[0] = 32'd100; rt_v[0] = 32'd7;
    @(negedge clk); start_v[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) begin
        start_v[0] = 1'b1; op_v[0] = 2'b01; hi_wr_v[0] = 1'b1; wr_v[0] = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start_v[0] = 1'b0; hi_wr_v[0] = 1'b0;
    end
    check("abort_busy_before", 64'(busy_v[0]), 64'(1));
    abort_v[0] = 1'b1;
    @(negedge clk); abort_v[0] = 1'b0;
    check("abort_busy_after", 64'(busy_v[0]), 64'(0));
    seen_done = done_v[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'(0));
    check("abort_hi_kept", 64'(hi_v[0]), 64'(pre_hi));
    check("abort_lo_kept", 64'(lo_v[0]), 64'(pre_lo));

    // Randomized ops on both instances
    for (int k = 0; k < 24; k++) begin
      int rd;
      logic [1:0] ro;
      logic [31:0] ra, rb;
      rd = int'($urandom_range(1, 0));
      ro = 2'($urandom_range(3, 0));
      ra = $urandom();
      if ($urandom_range(5, 0) == 0) rb = 32'h0;
      else if ($urandom_range(2, 0) == 0) rb = 32'($urandom_range(15, 0)) | 32'h1;
      else rb = $urandom();
      if ($urandom_range(3, 0) == 0) ra = ra | 32'h8000_0000;
      run_op(rd, ro, ra, rb, 1'b0, 32'h0, "rand");
    end

    // Reset asserted mid-CALC, then a normal op
    @(negedge clk); start_v[0] = 1'b1; op_v[0] = 2'b01; rs_v[0] = 32'd1234; rt_v[0] = 32'd99;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_v), 64'(0));
    check("midrst_done", 64'(done_v), 64'(0));
    check("midrst_dz", 64'(dz_v), 64'(0));
    check("midrst_hi", 64'({hi_v[1], hi_v[0]}), 64'(0));
    check("midrst_lo", 64'({lo_v[1], lo_v[0]}), 64'(0));
    @(negedge clk); reset = 1'b1;
    run_op(0, 2'b00, 32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b0, 32'h0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
